// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access types, error
// codes, FSM state encoding and access-legality helpers.
package riscv_lsu_pkg;

   localparam logic [2:0] RW_B  = 3'b000;
   localparam logic [2:0] RW_H  = 3'b001;
   localparam logic [2:0] RW_W  = 3'b010;
   localparam logic [2:0] RW_BU = 3'b100;
   localparam logic [2:0] RW_HU = 3'b101;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_REQ    = 2'b01,
      ST_WAIT_R = 2'b10,
      ST_DONE   = 2'b11
   } lsu_state_e;

   // True for the five funct3 encodings the core issues to memory.
   function automatic logic rw_legal(input logic [2:0] t);
      case (t)
         RW_B, RW_H, RW_W, RW_BU, RW_HU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never fault.
   function automatic logic rw_misaligned(input logic [2:0] t, input logic [1:0] a);
      case (t)
         RW_H, RW_HU: return a[0];
         RW_W:        return (a != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering for the LSU.
//   rw_type, addr_lo : access size/sign and byte offset within the word
//   wdata            : right-justified store data -> be_c / wdata_c (lane-replicated)
//   rdata            : raw bus word -> rdata_c (selected and sign/zero-extended)
module lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  rw_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be_c,
   output logic [31:0] wdata_c,
   output logic [31:0] rdata_c
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      be_c    = 4'b0000;
      wdata_c = 32'h0;
      rdata_c = 32'h0;
      shifted = rdata >> {addr_lo, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (rw_type)
         RW_B, RW_BU: begin
            be_c    = 4'b0001 << addr_lo;
            wdata_c = {4{wdata[7:0]}};
            rdata_c = (rw_type == RW_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
         end
         RW_H, RW_HU: begin
            be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata[15:0]}};
            rdata_c = (rw_type == RW_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
         end
         RW_W: begin
            be_c    = 4'b1111;
            wdata_c = wdata;
            rdata_c = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: accepts one access from EX/MEM, runs a
// req/gnt/rvalid bus transaction, and returns a one-cycle response.
//   req_*   : access from the pipeline (held stable while stall=1)
//   flush   : abandon the access before the bus grants it
//   stall   : combinational pipeline hold
//   rsp_*   : registered completion pulse, load data and error code
//   bus_*   : registered request to data memory; gnt/rvalid/rdata back
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        rw_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        rsp_err_code,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   localparam int unsigned     CNT_W    = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cap_we_q, cap_we_d;
   logic [2:0]        cap_type_q, cap_type_d;
   logic [1:0]        cap_off_q, cap_off_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [1:0]        rsp_err_code_q, rsp_err_code_d;

   logic [2:0]  al_type;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        timed_out;

   // Aligner sees the live request in IDLE and the captured one afterwards.
   always_comb begin
      al_type = cap_type_q;
      al_off  = cap_off_q;
      if (state_q == ST_IDLE) begin
         al_type = rw_type;
         al_off  = req_addr[1:0];
      end
   end

   lsu_align u_align (
      .rw_type (al_type),
      .addr_lo (al_off),
      .wdata   (req_wdata),
      .rdata   (bus_rdata),
      .be_c    (al_be),
      .wdata_c (al_wdata),
      .rdata_c (al_rdata)
   );

   assign timed_out = (cnt_q == CNT_LAST);

   // Next-state, capture, watchdog and registered-output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      cap_we_d       = cap_we_q;
      cap_type_d     = cap_type_q;
      cap_off_d      = cap_off_q;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_be_d       = bus_be_q;
      bus_wdata_d    = bus_wdata_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = 32'h0;
      rsp_err_d      = 1'b0;
      rsp_err_code_d = ERR_NONE;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cap_we_d   = req_we;
               cap_type_d = rw_type;
               cap_off_d  = req_addr[1:0];
               if (!rw_legal(rw_type)) begin
                  state_d        = ST_DONE;
                  rsp_valid_d    = 1'b1;
                  rsp_err_d      = 1'b1;
                  rsp_err_code_d = ERR_ILLEGAL;
               end else if (rw_misaligned(rw_type, req_addr[1:0])) begin
                  state_d        = ST_DONE;
                  rsp_valid_d    = 1'b1;
                  rsp_err_d      = 1'b1;
                  rsp_err_code_d = ERR_MISALIGN;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = '0;
                  bus_req_d   = 1'b1;
                  bus_we_d    = req_we;
                  bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                  bus_be_d    = al_be;
                  bus_wdata_d = req_we ? al_wdata : 32'h0;
               end
            end
         end

         // Grant beats flush, flush beats the watchdog.
         ST_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus_gnt || flush || timed_out) begin
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_be_d    = 4'b0000;
               bus_wdata_d = 32'h0;
            end
            if (bus_gnt) begin
               state_d     = cap_we_q ? ST_DONE : ST_WAIT_R;
               rsp_valid_d = cap_we_q;
            end else if (flush) begin
               state_d = ST_IDLE;
            end else if (timed_out) begin
               state_d        = ST_DONE;
               rsp_valid_d    = 1'b1;
               rsp_err_d      = 1'b1;
               rsp_err_code_d = ERR_TIMEOUT;
            end
         end

         ST_WAIT_R: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus_rvalid) begin
               state_d     = ST_DONE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = al_rdata;
            end else if (timed_out) begin
               state_d        = ST_DONE;
               rsp_valid_d    = 1'b1;
               rsp_err_d      = 1'b1;
               rsp_err_code_d = ERR_TIMEOUT;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         cap_we_q       <= 1'b0;
         cap_type_q     <= 3'b000;
         cap_off_q      <= 2'b00;
         bus_req_q      <= 1'b0;
         bus_we_q       <= 1'b0;
         bus_addr_q     <= '0;
         bus_be_q       <= 4'b0000;
         bus_wdata_q    <= 32'h0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= 32'h0;
         rsp_err_q      <= 1'b0;
         rsp_err_code_q <= ERR_NONE;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cap_we_q       <= cap_we_d;
         cap_type_q     <= cap_type_d;
         cap_off_q      <= cap_off_d;
         bus_req_q      <= bus_req_d;
         bus_we_q       <= bus_we_d;
         bus_addr_q     <= bus_addr_d;
         bus_be_q       <= bus_be_d;
         bus_wdata_q    <= bus_wdata_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_err_q      <= rsp_err_d;
         rsp_err_code_q <= rsp_err_code_d;
      end
   end

   // Hold the pipeline from acceptance until the DONE cycle.
   assign stall = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                  ((state_q == ST_IDLE) && req_valid);

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_be       = bus_be_q;
   assign bus_wdata    = bus_wdata_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_err_code = rsp_err_code_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: inputs driven and outputs sampled around the
// falling edge so each sample shows the state of the current rising-edge cycle.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, flush;
   logic [2:0]  rw_type;
   logic [31:0] req_addr, req_wdata;
   logic        stall, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err_code;
   logic        bus_req, bus_we, bus_gnt, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_lsu #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .rw_type      (rw_type),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .flush        (flush),
      .stall        (stall),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .rsp_err_code (rsp_err_code),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_be       (bus_be),
      .bus_wdata    (bus_wdata),
      .bus_gnt      (bus_gnt),
      .bus_rvalid   (bus_rvalid),
      .bus_rdata    (bus_rdata)
   );

   task automatic drive_req(input logic v, input logic we, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      req_we    = we;
      rw_type   = t;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic clear_bus_in();
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      flush      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      clear_bus_in();
      @(negedge clk); #1;
      checks++;
      if ({stall, bus_req, bus_we, bus_be, rsp_valid, rsp_err, rsp_err_code} !== 11'b0)
         begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {stall, bus_req, bus_we, bus_be, rsp_valid, rsp_err, rsp_err_code}); end
      checks++;
      if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || rsp_rdata !== 32'h0)
         begin errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h exp 0", bus_addr, bus_wdata, rsp_rdata); end
      req_valid = 1'b1; #1;
      checks++;
      if (stall !== 1'b1 || bus_req !== 1'b0)
         begin errors++; $display("FAIL reset_stall: stall %b bus_req %b exp 1 0", stall, bus_req); end
      req_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_lh();
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0); #1;
      checks++;
      if ({stall, bus_req, rsp_valid} !== 3'b100)
         begin errors++; $display("FAIL lh_c0: stall/req/rsp %b exp 100", {stall, bus_req, rsp_valid}); end
      @(negedge clk); bus_gnt = 1'b1; #1;
      checks++;
      if ({stall, bus_req, bus_we, bus_be} !== 7'b1101100 || bus_addr !== 32'h0000_0100)
         begin errors++; $display("FAIL lh_c1: stall/req/we/be %b addr %h exp 1101100 00000100", {stall, bus_req, bus_we, bus_be}, bus_addr); end
      @(negedge clk); bus_gnt = 1'b0; #1;
      checks++;
      if ({stall, bus_req, rsp_valid} !== 3'b100)
         begin errors++; $display("FAIL lh_c2: stall/req/rsp %b exp 100", {stall, bus_req, rsp_valid}); end
      @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'h8001_1234; #1;
      checks++;
      if ({stall, bus_req, rsp_valid} !== 3'b100)
         begin errors++; $display("FAIL lh_c3: stall/req/rsp %b exp 100", {stall, bus_req, rsp_valid}); end
      @(negedge clk); bus_rvalid = 1'b0; bus_rdata = 32'h0; #1;
      checks++;
      if ({stall, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'hFFFF_8001)
         begin errors++; $display("FAIL lh_done: stall/rsp/err %b rdata %h exp 010 ffff8001", {stall, rsp_valid, rsp_err}, rsp_rdata); end
      @(negedge clk); req_valid = 1'b0; #1;
      checks++;
      if ({stall, rsp_valid} !== 2'b00 || rsp_rdata !== 32'h0)
         begin errors++; $display("FAIL lh_after: stall/rsp %b rdata %h exp 00 0", {stall, rsp_valid}, rsp_rdata); end
   endtask

   task automatic test_sb();
      int pulses = 0;
      @(negedge clk); drive_req(1'b1, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_56AB); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bus_gnt = (i == 3); #1;
         checks++;
         if ({stall, bus_req, bus_we, bus_be, rsp_valid} !== 8'b11110000 ||
             bus_wdata !== 32'hABAB_ABAB || bus_addr !== 32'h0000_0200)
            begin errors++; $display("FAIL sb_req%0d: ctrl %b wdata %h addr %h exp 11110000 abababab 00000200", i, {stall, bus_req, bus_we, bus_be, rsp_valid}, bus_wdata, bus_addr); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); bus_gnt = 1'b0; req_valid = (i == 0); #1;
         if (rsp_valid === 1'b1) pulses++;
         if (i == 0) begin
            checks++;
            if ({stall, bus_req, bus_we, rsp_err} !== 4'b0000 || rsp_rdata !== 32'h0)
               begin errors++; $display("FAIL sb_done: stall/req/we/err %b rdata %h exp 0000 0", {stall, bus_req, bus_we, rsp_err}, rsp_rdata); end
         end
      end
      checks++;
      if (pulses !== 1)
         begin errors++; $display("FAIL sb_pulses: got %0d exp 1", pulses); end
   endtask

   task automatic test_err();
      logic [2:0]  types [4] = '{3'b010, 3'b001, 3'b011, 3'b110};
      logic [31:0] addrs [4] = '{32'h106, 32'h101, 32'h0, 32'h4};
      logic [1:0]  codes [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); drive_req(1'b1, 1'b0, types[k], addrs[k], 32'h0); #1;
         checks++;
         if ({stall, bus_req, rsp_valid} !== 3'b100)
            begin errors++; $display("FAIL err%0d_c0: stall/req/rsp %b exp 100", k, {stall, bus_req, rsp_valid}); end
         @(negedge clk); #1;
         checks++;
         if ({stall, bus_req, rsp_valid, rsp_err, rsp_err_code} !== {4'b0011, codes[k]} || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL err%0d_c1: stall/req/rsp/err/code %b rdata %h exp 0011%b", k, {stall, bus_req, rsp_valid, rsp_err, rsp_err_code}, rsp_rdata, codes[k]); end
         @(negedge clk); req_valid = 1'b0; #1;
         checks++;
         if ({bus_req, rsp_valid} !== 2'b00)
            begin errors++; $display("FAIL err%0d_c2: req/rsp %b exp 00", k, {bus_req, rsp_valid}); end
      end
   endtask

   task automatic test_timeout();
      int  req_cycles = 0;
      bit  seen = 0;
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'h0); #1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (rsp_valid === 1'b1) begin
            seen = 1;
            checks++;
            if ({bus_req, rsp_err, rsp_err_code, stall} !== 5'b01100 || rsp_rdata !== 32'h0)
               begin errors++; $display("FAIL to_done: req/err/code/stall %b rdata %h exp 01100 0", {bus_req, rsp_err, rsp_err_code, stall}, rsp_rdata); end
         end else if (bus_req === 1'b1) begin
            req_cycles++;
         end
      end
      checks++;
      if (!seen || req_cycles !== 8)
         begin errors++; $display("FAIL to_len: done %0d bus_req cycles %0d exp 1 8", seen, req_cycles); end
      @(negedge clk); req_valid = 1'b0; bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
      @(negedge clk); clear_bus_in(); #1;
      checks++;
      if ({rsp_valid, bus_req, stall} !== 3'b000)
         begin errors++; $display("FAIL to_stray: rsp/req/stall %b exp 000", {rsp_valid, bus_req, stall}); end
   endtask

   task automatic test_flush();
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0); #1;
      @(negedge clk); flush = 1'b1; #1;
      checks++;
      if (bus_req !== 1'b1)
         begin errors++; $display("FAIL fl_req: bus_req %b exp 1", bus_req); end
      @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
      checks++;
      if ({bus_req, rsp_valid, stall} !== 3'b000)
         begin errors++; $display("FAIL fl_idle: req/rsp/stall %b exp 000", {bus_req, rsp_valid, stall}); end
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0)
         begin errors++; $display("FAIL fl_norsp: rsp_valid %b exp 0", rsp_valid); end
      @(negedge clk); drive_req(1'b1, 1'b1, 3'b010, 32'h0000_0044, 32'hDEAD_BEEF); #1;
      @(negedge clk); flush = 1'b1; bus_gnt = 1'b1; #1;
      checks++;
      if ({bus_req, bus_we, bus_be} !== 6'b111111 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h44)
         begin errors++; $display("FAIL flg_req: req/we/be %b wdata %h addr %h exp 111111 deadbeef 44", {bus_req, bus_we, bus_be}, bus_wdata, bus_addr); end
      @(negedge clk); clear_bus_in(); #1;
      checks++;
      if ({rsp_valid, rsp_err, bus_req, stall} !== 4'b1000)
         begin errors++; $display("FAIL flg_done: rsp/err/req/stall %b exp 1000", {rsp_valid, rsp_err, bus_req, stall}); end
      @(negedge clk); req_valid = 1'b0; #1;
   endtask

   task automatic test_async_reset();
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b000, 32'h0000_0008, 32'h0); #1;
      @(negedge clk); bus_gnt = 1'b1; #1;
      @(negedge clk); bus_gnt = 1'b0; #1;
      checks++;
      if ({stall, bus_req} !== 2'b10)
         begin errors++; $display("FAIL ar_wait: stall/req %b exp 10", {stall, bus_req}); end
      #1 rst = 1'b1;
      req_valid = 1'b0; #1;
      checks++;
      if ({stall, bus_req, rsp_valid, rsp_err, bus_be} !== 8'b0 || bus_addr !== 32'h0 || rsp_rdata !== 32'h0)
         begin errors++; $display("FAIL ar_async: ctrl %b addr %h rdata %h exp 0", {stall, bus_req, rsp_valid, rsp_err, bus_be}, bus_addr, rsp_rdata); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0); #1;
      @(negedge clk); bus_gnt = 1'b1; #1;
      checks++;
      if ({bus_req, bus_be} !== 5'b11111 || bus_addr !== 32'h0)
         begin errors++; $display("FAIL ar_lw_req: req/be %b addr %h exp 11111 0", {bus_req, bus_be}, bus_addr); end
      @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
      @(negedge clk); clear_bus_in(); #1;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hCAFE_F00D)
         begin errors++; $display("FAIL ar_lw_done: rsp/err %b rdata %h exp 10 cafef00d", {rsp_valid, rsp_err}, rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      // DONE cycle of the previous LW: the next access is presented right after.
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0); #1;
      checks++;
      if ({stall, bus_req} !== 2'b10)
         begin errors++; $display("FAIL b2b_acc1: stall/req %b exp 10", {stall, bus_req}); end
      @(negedge clk); bus_gnt = 1'b1; #1;
      @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11F2_8033; #1;
      @(negedge clk); clear_bus_in(); #1;
      checks++;
      if ({rsp_valid, stall} !== 2'b10 || rsp_rdata !== 32'h0000_0080)
         begin errors++; $display("FAIL b2b_lbu: rsp/stall %b rdata %h exp 10 00000080", {rsp_valid, stall}, rsp_rdata); end
      @(negedge clk); drive_req(1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0); #1;
      checks++;
      if ({stall, bus_req, rsp_valid} !== 3'b100)
         begin errors++; $display("FAIL b2b_acc2: stall/req/rsp %b exp 100", {stall, bus_req, rsp_valid}); end
      @(negedge clk); bus_gnt = 1'b1; #1;
      checks++;
      if ({bus_req, bus_we, bus_be} !== 6'b100100)
         begin errors++; $display("FAIL b2b_be: req/we/be %b exp 100100", {bus_req, bus_we, bus_be}); end
      @(negedge clk); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00F3_0000; #1;
      @(negedge clk); clear_bus_in(); #1;
      checks++;
      if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hFFFF_FFF3)
         begin errors++; $display("FAIL b2b_lb: rsp/err %b rdata %h exp 10 fffffff3", {rsp_valid, rsp_err}, rsp_rdata); end
      @(negedge clk); drive_req(1'b1, 1'b1, 3'b001, 32'h0000_0002, 32'h5555_1234); #1;
      @(negedge clk); bus_gnt = 1'b1; #1;
      checks++;
      if ({bus_req, bus_we, bus_be} !== 6'b111100 || bus_wdata !== 32'h1234_1234)
         begin errors++; $display("FAIL b2b_sh: req/we/be %b wdata %h exp 111100 12341234", {bus_req, bus_we, bus_be}, bus_wdata); end
      @(negedge clk); bus_gnt = 1'b0; #1;
      @(negedge clk); req_valid = 1'b0; #1;
   endtask

   initial begin
      test_reset();
      test_lh();
      test_sb();
      test_err();
      test_timeout();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit for the pipelined RISC-V core, in the MEM stage between the EX/MEM pipeline register and the data-memory bus. Replaces the direct single-cycle wiring of the read/write enables, RW type and ALU-result address to RAM. Adds:
- a request/grant/rvalid bus handshake with variable latency;
- byte-enable generation and load sign/zero extension;
- misalignment detection and a bus-timeout watchdog;
- a stall output that freezes the pipeline while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on request and bus side.
- TIMEOUT_CYC, 255, maximum cycles from bus_req assertion to completion before timeout error; must be ≥ 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM holds a memory instruction.
- req_we  in  1  store (1) / load (0).
- rw_type  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. 011, 110 and 111 are illegal.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data, right-justified.
- flush  in  1  kill the current access; honoured only before grant.
- stall  out  1  pipeline hold request.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- rsp_err  out  1  access failed; qualified by rsp_valid.
- rsp_err_code  out  2  01 misaligned, 10 timeout, 11 illegal rw_type.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] are 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  bus accepted the request.
- bus_rvalid  in  1  read data valid; arrives at least 1 cycle after grant.
- bus_rdata  in  32  read word.

## Operation
The FSM has four states: IDLE, REQ, WAIT_R, DONE.

- **IDLE:** a new access is accepted when req_valid=1. Request fields are captured into internal registers.
  - Misaligned or illegal access → DONE with rsp_err=1 and the matching code. No bus activity.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise → REQ.
- **REQ:** bus_req=1 and the bus fields are driven from the captured registers.
  - bus_gnt=1 with a store → DONE.
  - bus_gnt=1 with a load → WAIT_R.
  - flush=1 with bus_gnt=0 → IDLE. No rsp_valid is issued and bus_req is dropped.
  - If bus_gnt and flush are both high in the same cycle, the grant wins.
- **WAIT_R:** on bus_rvalid, bus_rdata is steered through the aligner and captured → DONE. flush is ignored in this state.
- **DONE:** rsp_valid=1 for one cycle → IDLE.
- **Timeout:**
  - An 8+ bit counter clears on entry to REQ and increments every cycle in REQ or WAIT_R.
  - When it equals TIMEOUT_CYC-1 and the state has not completed, the FSM goes to DONE with error code 10 and bus_req drops.
  - A late bus_rvalid or bus_gnt seen in IDLE is ignored.
- **Stall:** stall = (state≠IDLE and state≠DONE) or (state==IDLE and req_valid).
  - It is combinational and drops in the DONE cycle so the pipeline advances.
  - Request inputs must stay stable while stall=1.
- **Byte enables:**
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 shifted left by 2×addr[1].
  - W: 1111.
  - bus_wdata replicates the byte or halfword across all lanes.
- **Loads:** the byte or halfword is selected by addr[1:0]. B and H sign-extend; BU and HU zero-extend.

## Timing
- Reset values: state=IDLE, all bus_* outputs = 0, rsp_* = 0, counter = 0. stall = req_valid.
- Reset asserted mid-operation aborts immediately; bus_req drops asynchronously.
- Fastest store: accept in c0, bus_req and bus_gnt in c1, rsp_valid in c2. stall is high in c0–c1.
- Fastest load: accept in c0, grant in c1, rvalid in c2, rsp_valid with rsp_rdata in c3.
- Misaligned or illegal access: rsp_valid in c1 and no bus_req at any point.
- Back-to-back accesses: the next request can be accepted in the cycle after DONE.

## Structure
- Package riscv_lsu_pkg holds:
  - rw_type localparams (RW_B, RW_H, RW_W, RW_BU, RW_HU);
  - the FSM state enum;
  - error-code constants ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
- Sub-module lsu_align is combinational and contains:
  - be/wdata generation from rw_type, addr[1:0] and wdata;
  - load extraction and extension from rw_type, addr[1:0] and rdata.
- The FSM, capture registers and watchdog live in riscv_lsu.

## Test plan
- **LH from 0x102, rdata 0x8001_xxxx, grant in 1 cycle, rvalid 2 cycles later:** bus_be=1100, bus_addr=0x100, rsp_rdata=0xFFFF_8001. stall covers every cycle up to but not including DONE.
- **SB 0xAB to 0x203, grant after 3 wait cycles:** bus_be=1000, bus_wdata=0xABAB_ABAB, bus_we=1 held until grant, then a single rsp_valid.
- **LW at 0x106:** rsp_valid in the next cycle, rsp_err=1, code 01, bus_req never asserted.
- **LBU with the bus never granting, TIMEOUT_CYC=8:**
  - bus_req is high for exactly 8 cycles, then rsp_err=1 with code 10.
  - A later stray rvalid in IDLE causes no rsp_valid.
- **Flush in REQ with no grant:** returns to IDLE, no rsp_valid. A flush in the same cycle as grant completes normally.
- **Async reset asserted in WAIT_R:** all outputs return to reset values without waiting for a clock edge. A following LW at 0x0 completes normally.
